// File: rtl/hilo_mul_unit.sv
// rtl/hilo_mul_unit.sv - multi-cycle signed multiplier with HI/LO pair (optional HILO_MULTU_EN adds multu)
module hilo_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult,
`ifdef HILO_MULTU_EN
    input  logic             multu,
`endif
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_q;

    logic               start_d;
    logic               uns_d;
    logic               neg_d;
    logic               any_op_d;
    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] product_d;

`ifdef HILO_MULTU_EN
    assign start_d  = mult | multu;
    assign uns_d    = multu & ~mult;
    assign any_op_d = mult | multu | mfhi | mflo | mthi | mtlo;
`else
    assign start_d  = mult;
    assign uns_d    = 1'b0;
    assign any_op_d = mult | mfhi | mflo | mthi | mtlo;
`endif

    // Magnitudes are unsigned WIDTH bits, so the most negative operand maps onto itself exactly.
    assign mag_a_d   = (a[WIDTH-1] & ~uns_d) ? -a : a;
    assign mag_b_d   = (b[WIDTH-1] & ~uns_d) ? -b : b;
    assign neg_d     = ~uns_d & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign product_d = neg_q ? -acc_q : acc_q;

    assign busy     = (state_q != S_IDLE);
    assign stall    = busy & any_op_d;
    assign hilo_out = mfhi ? hi_q : lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
                        mplier_q <= mag_b_d;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                    end else if (mthi) begin
                        hi_q <= a;
                    end else if (mtlo) begin
                        lo_q <= a;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= product_d[2*WIDTH-1:WIDTH];
                    lo_q    <= product_d[WIDTH-1:0];
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
